// File: rtl/icache_ctrl_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// icache_ctrl_if : fetch, tag/valid RAM, memory and data-array fill bundle
// Revision 1.0 - initial release
// ---------------------------------------------------------------------------
interface icache_ctrl_if #(
  parameter int TAG_W = 23,
  parameter int IDX_W = 5,
  parameter int BEATS = 4
);
  localparam int c_off_w  = 32 - TAG_W - IDX_W;
  localparam int c_beat_w = $clog2(BEATS);

  logic                 req_valid;
  logic [31:0]          req_addr;
  logic                 req_ready;
  logic                 flush;

  logic                 resp_valid;
  logic [IDX_W-1:0]     resp_index;
  logic [c_off_w-1:0]   resp_offset;

  logic [IDX_W-1:0]     tag_index;
  logic                 tag_wr;
  logic [TAG_W-1:0]     tag_wr_data;
  logic [TAG_W-1:0]     tag_rd_data;
  logic                 val_wr;
  logic                 val_wr_data;
  logic                 val_rd_data;

  logic                 mem_req;
  logic [31:0]          mem_addr;
  logic                 mem_ack;
  logic [31:0]          mem_data;

  logic                 fill_wr;
  logic [IDX_W-1:0]     fill_index;
  logic [c_beat_w-1:0]  fill_word;
  logic [31:0]          fill_data;

  // Controller side.
  modport slave (
    input  req_valid, req_addr, flush,
    input  tag_rd_data, val_rd_data,
    input  mem_ack, mem_data,
    output req_ready, resp_valid, resp_index, resp_offset,
    output tag_index, tag_wr, tag_wr_data, val_wr, val_wr_data,
    output mem_req, mem_addr,
    output fill_wr, fill_index, fill_word, fill_data
  );

  // Environment side: fetch unit, RAM arrays and memory.
  modport master (
    output req_valid, req_addr, flush,
    output tag_rd_data, val_rd_data,
    output mem_ack, mem_data,
    input  req_ready, resp_valid, resp_index, resp_offset,
    input  tag_index, tag_wr, tag_wr_data, val_wr, val_wr_data,
    input  mem_req, mem_addr,
    input  fill_wr, fill_index, fill_word, fill_data
  );
endinterface
`default_nettype wire

// File: rtl/icache_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// icache_ctrl : I-cache lookup, 4-beat miss fill and full valid-bit flush
// Revision 1.0 - initial release
// ---------------------------------------------------------------------------
module icache_ctrl #(
  parameter int TAG_W = 23,
  parameter int IDX_W = 5,
  parameter int BEATS = 4
) (
  input  wire logic    clk,
  input  wire logic    reset,
  icache_ctrl_if.slave bus
);
  localparam int c_off_w  = 32 - TAG_W - IDX_W;
  localparam int c_beat_w = $clog2(BEATS);

  localparam logic [2:0] c_idle   = 3'd0;
  localparam logic [2:0] c_lookup = 3'd1;
  localparam logic [2:0] c_fill   = 3'd2;
  localparam logic [2:0] c_update = 3'd3;
  localparam logic [2:0] c_flush  = 3'd4;

  localparam logic [IDX_W-1:0]    c_last_idx  = '1;
  localparam logic [c_beat_w-1:0] c_last_beat = c_beat_w'(BEATS - 1);

  logic [2:0]          r_state;
  logic [c_beat_w-1:0] r_beat;
  logic [IDX_W-1:0]    r_flush_cnt;
  logic                r_flush_pend;
  logic [31:0]         r_addr;

  logic [2:0]          w_state_nxt;
  logic [TAG_W-1:0]    w_tag;
  logic [IDX_W-1:0]    w_idx;
  logic [c_off_w-1:0]  w_off;
  logic                w_hit;
  logic                w_ready;
  logic                w_accept;
  logic                w_flush_go;
  logic                w_beat_done;

  assign w_tag       = r_addr[31 -: TAG_W];
  assign w_idx       = r_addr[c_off_w +: IDX_W];
  assign w_off       = r_addr[c_off_w-1:0];
  assign w_hit       = bus.val_rd_data && (bus.tag_rd_data == w_tag);
  assign w_ready     = (r_state == c_idle) && !bus.flush && !r_flush_pend;
  assign w_accept    = bus.req_valid && w_ready;
  assign w_flush_go  = (r_state == c_idle) && (bus.flush || r_flush_pend);
  assign w_beat_done = (r_state == c_fill) && bus.mem_ack;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_idle: begin
        if (w_flush_go) begin
          w_state_nxt = c_flush;
        end else if (w_accept) begin
          w_state_nxt = c_lookup;
        end
      end
      c_lookup: w_state_nxt = w_hit ? c_idle : c_fill;
      c_fill: begin
        if (w_beat_done && (r_beat == c_last_beat)) begin
          w_state_nxt = c_update;
        end
      end
      // The replay lookup after the update is what finally answers the fetch.
      c_update: w_state_nxt = c_lookup;
      c_flush: begin
        if (r_flush_cnt == c_last_idx) begin
          w_state_nxt = c_idle;
        end
      end
      default: w_state_nxt = c_idle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= c_idle;
      r_beat       <= '0;
      r_flush_cnt  <= '0;
      r_flush_pend <= 1'b0;
      r_addr       <= '0;
    end else begin
      r_state <= w_state_nxt;

      // Entering FLUSH consumes the pending request, including a same-cycle one.
      if (w_flush_go) begin
        r_flush_pend <= 1'b0;
      end else if (bus.flush) begin
        r_flush_pend <= 1'b1;
      end

      if (w_accept) begin
        r_addr <= bus.req_addr;
      end

      if (r_state == c_lookup) begin
        r_beat <= '0;
      end else if (w_beat_done) begin
        r_beat <= r_beat + c_beat_w'(1);
      end

      if (r_state == c_flush) begin
        r_flush_cnt <= r_flush_cnt + IDX_W'(1);
      end
    end
  end

  assign bus.req_ready   = w_ready;
  assign bus.resp_valid  = (r_state == c_lookup) && w_hit;
  assign bus.resp_index  = w_idx;
  assign bus.resp_offset = w_off;

  assign bus.tag_index   = (r_state == c_flush) ? r_flush_cnt : w_idx;
  assign bus.tag_wr      = (r_state == c_update);
  assign bus.tag_wr_data = w_tag;
  assign bus.val_wr      = (r_state == c_update) || (r_state == c_flush);
  assign bus.val_wr_data = (r_state == c_update);

  assign bus.mem_req     = (r_state == c_fill);
  assign bus.mem_addr    = {w_tag, w_idx, r_beat, {(c_off_w - c_beat_w){1'b0}}};

  // Data is gated so the array sees zero outside an actual beat.
  assign bus.fill_wr     = w_beat_done;
  assign bus.fill_index  = w_idx;
  assign bus.fill_word   = r_beat;
  assign bus.fill_data   = w_beat_done ? bus.mem_data : 32'd0;

endmodule
`default_nettype wire

// File: tb/tb_icache_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_icache_ctrl : directed bench with a transaction-level cache model
// Revision 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_icache_ctrl;
  logic clk;
  logic rst_n;
  logic ram_clear;

  int n_tests = 0;
  int n_fail  = 0;
  int ack_period = 1;
  int ack_cnt = 0;
  int k_main, fw0, cnt;

  icache_ctrl_if bus();

  icache_ctrl dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  // Tag and valid arrays with combinational read.
  logic [22:0] tag_ram [32];
  logic [31:0] val_ram;
  assign bus.tag_rd_data = tag_ram[bus.tag_index];
  assign bus.val_rd_data = val_ram[bus.tag_index];

  always @(posedge clk) begin
    if (ram_clear) begin
      val_ram <= '0;
      for (int i = 0; i < 32; i++) tag_ram[i] <= '0;
    end else begin
      if (bus.tag_wr) tag_ram[bus.tag_index] <= bus.tag_wr_data;
      if (bus.val_wr) val_ram[bus.tag_index] <= bus.val_wr_data;
    end
  end

  // Memory: acks every ack_period-th cycle of an outstanding request.
  always @(posedge clk) begin
    #1;
    if (rst_n && bus.mem_req) begin
      ack_cnt      = ack_cnt + 1;
      bus.mem_ack  = (ack_cnt % ack_period) == 0;
      bus.mem_data = $urandom;
    end else begin
      ack_cnt      = 0;
      bus.mem_ack  = 1'b0;
      bus.mem_data = 32'd0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h required 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: cache contents plus the lifetime of the one outstanding fetch and flush.
  logic        m_valid [32];
  logic [22:0] m_tag   [32];
  logic        m_busy = 1'b0;
  logic        m_hit = 1'b0;
  logic        m_flush_pend = 1'b0;
  logic [31:0] m_addr = '0;
  int          m_cyc = 0, m_acks = 0, m_last_ack = 0, m_flush_left = 0;
  int          flush_writes = 0, log_resp_cyc = -1;
  logic [31:0] log_tag_data, log_tag_idx, log_resp_idx, log_resp_off;
  logic [31:0] fill_log [$];
  logic        idle_now, e_mreq, e_twr, e_vwr, e_fill, e_resp;
  logic [31:0] line;
  logic [22:0] m_t;
  logic [4:0]  m_i;

  always @(negedge clk) begin
    if (ram_clear) begin
      for (int i = 0; i < 32; i++) begin
        m_valid[i] = 1'b0;
        m_tag[i]   = '0;
      end
    end
    if (!rst_n) begin
      chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
      chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
      chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
      chk("rst_tag_wr", 32'(bus.tag_wr), 32'd0);
      chk("rst_val_wr", 32'(bus.val_wr), 32'd0);
      chk("rst_fill_wr", 32'(bus.fill_wr), 32'd0);
      chk("rst_mem_addr", bus.mem_addr, 32'd0);
      chk("rst_fill_data", bus.fill_data, 32'd0);
      chk("rst_tag_index", 32'(bus.tag_index), 32'd0);
      m_busy = 1'b0;
      m_flush_left = 0;
      m_flush_pend = 1'b0;
    end else begin
      idle_now = !m_busy && (m_flush_left == 0);
      chk("req_ready", 32'(bus.req_ready), 32'(idle_now && !m_flush_pend && !bus.flush));
      e_mreq = 0; e_twr = 0; e_vwr = 0; e_fill = 0; e_resp = 0;

      if (m_flush_left > 0) begin
        e_vwr = 1'b1;
        chk("flush_index", 32'(bus.tag_index), 32'(32 - m_flush_left));
        chk("flush_val_data", 32'(bus.val_wr_data), 32'd0);
        m_valid[5'(32 - m_flush_left)] = 1'b0;
        if (bus.val_wr && !bus.val_wr_data) flush_writes++;
      end

      if (m_busy) begin
        m_cyc++;
        line = {m_addr[31:4], 4'h0};
        m_t  = m_addr[31:9];
        m_i  = m_addr[8:4];
        if (m_hit) begin
          e_resp = (m_cyc == 1);
        end else begin
          e_mreq = (m_cyc >= 2) && (m_acks < 4);
          e_twr  = (m_acks == 4) && (m_cyc == m_last_ack + 1);
          e_resp = (m_acks == 4) && (m_cyc == m_last_ack + 2);
        end
        if (m_cyc == 1 || e_resp) chk("lookup_index", 32'(bus.tag_index), 32'(m_i));
        if (e_mreq) begin
          chk("mem_addr", bus.mem_addr, line + 32'(m_acks * 4));
          e_fill = bus.mem_ack;
          if (bus.mem_ack) begin
            chk("fill_index", 32'(bus.fill_index), 32'(m_i));
            chk("fill_word", 32'(bus.fill_word), 32'(m_acks));
            chk("fill_data", bus.fill_data, bus.mem_data);
            fill_log.push_back(bus.mem_addr);
            m_acks++;
            m_last_ack = m_cyc;
          end
        end
        if (e_twr) begin
          e_vwr = 1'b1;
          chk("update_index", 32'(bus.tag_index), 32'(m_i));
          chk("update_tag", 32'(bus.tag_wr_data), 32'(m_t));
          chk("update_val_data", 32'(bus.val_wr_data), 32'd1);
          log_tag_data = 32'(bus.tag_wr_data);
          log_tag_idx  = 32'(bus.tag_index);
          m_valid[m_i] = 1'b1;
          m_tag[m_i]   = m_t;
        end
        if (bus.resp_valid && log_resp_cyc < 0) begin
          log_resp_cyc = m_cyc;
          log_resp_idx = 32'(bus.resp_index);
          log_resp_off = 32'(bus.resp_offset);
        end
        if (e_resp) begin
          chk("resp_index", 32'(bus.resp_index), 32'(m_i));
          chk("resp_offset", 32'(bus.resp_offset), 32'(m_addr[3:0]));
          m_busy = 1'b0;
        end
      end

      chk("mem_req", 32'(bus.mem_req), 32'(e_mreq));
      chk("fill_wr", 32'(bus.fill_wr), 32'(e_fill));
      chk("tag_wr", 32'(bus.tag_wr), 32'(e_twr));
      chk("val_wr", 32'(bus.val_wr), 32'(e_vwr));
      chk("resp_valid", 32'(bus.resp_valid), 32'(e_resp));

      if (m_flush_left > 0) m_flush_left--;
      if (idle_now && (bus.flush || m_flush_pend)) begin
        m_flush_left = 32;
        m_flush_pend = 1'b0;
      end else begin
        if (bus.flush) m_flush_pend = 1'b1;
        if (idle_now && bus.req_valid) begin
          m_busy = 1'b1;
          m_addr = bus.req_addr;
          m_cyc  = 0;
          m_acks = 0;
          m_hit  = m_valid[bus.req_addr[8:4]] && (m_tag[bus.req_addr[8:4]] == bus.req_addr[31:9]);
        end
      end
    end
  end

  task automatic wait_ready();
    int k = 0;
    while (!bus.req_ready && k < 300) begin
      @(posedge clk); #1;
      k++;
    end
    chk("ready_wait", 32'(bus.req_ready), 32'd1);
  endtask

  task automatic do_req(input logic [31:0] addr, input int exp_cyc);
    int k = 0;
    fill_log.delete();
    log_resp_cyc = -1;
    log_tag_data = '1;
    log_tag_idx  = '1;
    @(posedge clk); #1;
    wait_ready();
    bus.req_valid = 1'b1;
    bus.req_addr  = addr;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    while (m_busy && k < 300) begin
      @(posedge clk); #1;
      k++;
    end
    chk("resp_wait", 32'(m_busy), 32'd0);
    chk("resp_cycle", 32'(log_resp_cyc), 32'(exp_cyc));
  endtask

  initial begin
    rst_n = 1'b1;
    ram_clear = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_addr  = '0;
    bus.flush     = 1'b0;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("lit_rst_ready", 32'(bus.req_ready), 32'd1);
    chk("lit_rst_mem_req", 32'(bus.mem_req), 32'd0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    ram_clear = 1'b0;

    // Cold miss, zero-wait memory.
    do_req(32'h001578C4, 7);
    chk("cold_fill_count", 32'(fill_log.size()), 32'd4);
    chk("cold_addr0", fill_log[0], 32'h001578C0);
    chk("cold_addr1", fill_log[1], 32'h001578C4);
    chk("cold_addr2", fill_log[2], 32'h001578C8);
    chk("cold_addr3", fill_log[3], 32'h001578CC);
    chk("cold_tag", log_tag_data, 32'h00000ABC);
    chk("cold_tag_idx", log_tag_idx, 32'd12);
    chk("cold_resp_idx", log_resp_idx, 32'd12);
    chk("cold_resp_off", log_resp_off, 32'd4);

    // Warm hit.
    do_req(32'h001578C4, 1);
    chk("hit_no_fill", 32'(fill_log.size()), 32'd0);
    chk("hit_resp_off", log_resp_off, 32'd4);

    // Same index, different tag: line is replaced.
    do_req(32'h000018C0, 7);
    chk("conflict_tag", log_tag_data, 32'h0000000C);
    chk("conflict_tag_idx", log_tag_idx, 32'd12);
    do_req(32'h001578C4, 7);
    do_req(32'h001578C8, 1);
    chk("hit2_resp_off", log_resp_off, 32'd8);

    // Wait-state memory: ack on every third cycle.
    ack_period = 3;
    do_req(32'h00002340, 15);
    chk("ws_fill_count", 32'(fill_log.size()), 32'd4);
    chk("ws_addr0", fill_log[0], 32'h00002340);
    chk("ws_addr3", fill_log[3], 32'h0000234C);
    chk("ws_tag", log_tag_data, 32'h00000011);
    ack_period = 1;

    // Single flush pulse in IDLE.
    fw0 = flush_writes;
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    cnt = 0;
    while (!bus.req_ready && cnt < 100) begin
      cnt++;
      @(posedge clk); #1;
    end
    chk("flush_busy_cycles", 32'(cnt), 32'd32);
    chk("flush_writes", 32'(flush_writes - fw0), 32'd32);
    do_req(32'h001578C4, 7);

    // Flush arriving mid-fill waits for the fetch to finish.
    fw0 = flush_writes;
    fork
      do_req(32'h000018C0, 7);
      begin
        repeat (3) @(posedge clk);
        #1 bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
      end
    join
    wait_ready();
    chk("deferred_flush_writes", 32'(flush_writes - fw0), 32'd32);

    // Flush during flush schedules exactly one more.
    fw0 = flush_writes;
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    repeat (5) @(posedge clk);
    #1 bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    wait_ready();
    chk("double_flush_writes", 32'(flush_writes - fw0), 32'd64);

    // Reset in the middle of a fill.
    wait_ready();
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'h00002340;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    k_main = 0;
    while (m_acks < 2 && k_main < 50) begin
      @(posedge clk);
      k_main++;
    end
    chk("midfill_acks", 32'(m_acks), 32'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("midfill_mem_req", 32'(bus.mem_req), 32'd0);
    chk("midfill_tag_wr", 32'(bus.tag_wr), 32'd0);
    chk("midfill_ready", 32'(bus.req_ready), 32'd1);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    do_req(32'h00002340, 7);
    chk("refill_count", 32'(fill_log.size()), 32'd4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/icache_ctrl.md
Name: icache_ctrl

Overview:
Instruction-cache lookup and miss controller that sits directly downstream of the itagRAM/ivalidRAM arrays. It owns their index and write ports and consumes their read outputs to produce hit/miss decisions. On a miss it performs a 4-beat line fill from memory, then writes the tag and sets the valid bit. It also sequences a full valid-bit flush. Geometry: 32 lines, 16-byte lines, 23-bit tag; address split is tag = addr[31:9], index = addr[8:4], offset = addr[3:0].

Parameters:
TAG_W, 23, tag width (addr[31:9])
IDX_W, 5, index width (32 lines)
BEATS, 4, 32-bit memory beats per line

Ports:
clk  in  1  clock; all state changes on rising edge
reset  in  1  asynchronous, active-low reset
req_valid  in  1  fetch request valid
req_addr  in  32  fetch byte address
req_ready  out  1  controller accepts a request this cycle
flush  in  1  request invalidation of all 32 lines
resp_valid  out  1  one-cycle pulse: requested line present
resp_index  out  5  index of the hit line
resp_offset  out  4  byte offset of the hit request
tag_index  out  5  index to tag and valid RAMs
tag_wr  out  1  tag RAM write enable
tag_wr_data  out  23  tag RAM write data
tag_rd_data  in  23  tag RAM read data (combinational on tag_index)
val_wr  out  1  valid RAM write enable
val_wr_data  out  1  valid RAM write data
val_rd_data  in  1  valid RAM read data (combinational on tag_index)
mem_req  out  1  memory read request, held until mem_ack
mem_addr  out  32  word address {tag, index, beat[1:0], 2'b00}
mem_ack  in  1  memory beat returned this cycle
mem_data  in  32  beat data
fill_wr  out  1  data-array write pulse
fill_index  out  5  data-array line index
fill_word  out  2  word within line
fill_data  out  32  data to data array

Behaviour:
- Reset (reset=0, async): state IDLE; beat=0; flush counter=0; flush_pend=0; addr register=0. All outputs 0 except req_ready, which is 1. An in-flight fill is abandoned: no tag or valid write occurs, and mem_req drops immediately.
- flush_pend: set when flush=1 in any state; cleared on entry to FLUSH.
- req_ready = (state==IDLE) & ~flush & ~flush_pend. flush has priority over req_valid in the same cycle.
- IDLE: if flush or flush_pend, go to FLUSH. Otherwise, on req_valid & req_ready, latch req_addr and go to LOOKUP.
- LOOKUP (1 cycle): tag_index = latched index.
  - Hit (val_rd_data=1 and tag_rd_data equals latched tag): resp_valid=1 with resp_index and resp_offset driven, then go to IDLE.
  - Miss: beat=0, go to FILL.
- FILL: mem_req=1; mem_addr = {tag, index, beat, 2'b00}.
  - On mem_ack: fill_wr=1 in the same cycle; fill_index = index, fill_word = beat, fill_data = mem_data; beat increments.
  - Ack on beat 3: go to UPDATE.
  - mem_addr is stable while mem_req=1 and no ack has arrived. Back-to-back acks are legal, giving a 4-cycle fill.
- UPDATE (1 cycle): tag_wr=1, tag_wr_data = latched tag; val_wr=1, val_wr_data=1; tag_index = index. Then go to LOOKUP (replay), which must hit.
- FLUSH: tag_index = counter; val_wr=1, val_wr_data=0; counter increments every cycle. After index 31 is written (32 cycles), counter wraps to 0 and the state goes to IDLE. flush asserted during FLUSH sets flush_pend again, so one further full flush follows.
- A flush arriving during FILL/UPDATE is deferred: the replay LOOKUP completes first, then IDLE enters FLUSH.
- Outside their active state, tag_wr, val_wr, fill_wr, mem_req and resp_valid are 0. tag_index defaults to the latched index.
- Latency, counted from the acceptance edge:
  - Hit: resp_valid in the next cycle.
  - Miss with 0-wait memory: 1 (LOOKUP) + 4 (FILL) + 1 (UPDATE) + 1 (LOOKUP) = resp_valid in cycle 7.

Test Plan:
- Cold miss: after reset release, request 0x001578C4 (tag 0xABC, index 12, offset 4) with mem_ack every cycle → mem_addr 0x001578C0/C4/C8/CC, fill_word 0..3, tag_wr with data 0xABC at index 12, val_wr=1, resp_valid in cycle 7 with resp_index=12, resp_offset=4.
- Warm hit: re-request 0x001578C4 → resp_valid on the next cycle, mem_req stays 0.
- Tag conflict: request 0x000018C0 (tag 0x00C, index 12), valid=1 but tag mismatch → miss, fill, tag overwritten with 0x00C.
- Wait-state fill: mem_ack only every 3rd cycle → mem_addr held constant between acks, exactly 4 fill_wr pulses.
- Flush: assert flush for 1 cycle in IDLE → req_ready=0 for 32 cycles, val_wr=1/val_wr_data=0 at indices 0..31. A following request to 0x001578C4 misses.
- Reset mid-fill: drive reset low after beat 1 ack → mem_req=0 immediately, no tag_wr. After release, the same request misses again.
